// File: rtl/i2s_mic_rx_if.sv
// Stereo frame handshake between the I2S microphone receiver and its consumer.
// The master holds left/right/valid; the slave answers with ready.
interface i2s_mic_rx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              valid;
    logic              ready;

    modport master (
        output left,
        output right,
        output valid,
        input  ready
    );

    modport slave (
        input  left,
        input  right,
        input  valid,
        output ready
    );
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a MEMS microphone: clock generation, word capture,
// frame hold register with sticky overrun, and a windowed left-channel peak.
module i2s_mic_rx #(
    parameter int DATA_W    = 24,
    parameter int PEAK_LOG2 = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic              bclk_o,
    output logic              lrclk_o,
    input  logic              sd_i,
    i2s_mic_rx_if.master      out,
    output logic              overrun_o,
    input  logic              overrun_clr_i,
    output logic [DATA_W-2:0] peak_o,
    output logic              peak_valid_o
);
    localparam logic [4:0] LAST = 5'(DATA_W);

    logic [9:0]           div_q, div_d;
    logic                 sd_m_q, sd_s_q;
    logic [DATA_W-1:0]    shift_q, lpend_q;
    logic [DATA_W-1:0]    left_q, right_q;
    logic                 valid_q, ovr_q, pv_q;
    logic [DATA_W-2:0]    run_q, peak_q;
    logic [PEAK_LOG2-1:0] cnt_q, cnt_d;

    logic              strobe, capture, done, fdone, accept;
    logic [4:0]        bit_idx;
    logic [DATA_W-1:0] word, neg;
    logic [DATA_W-2:0] abs_a, max_a;

    always_comb begin
        div_d   = div_q + 10'd1;
        bit_idx = div_q[8:4];
        strobe  = (div_q[3:0] == 4'b1011);
        capture = strobe && (bit_idx != 5'd0) && (bit_idx <= LAST);
        done    = strobe && (bit_idx == LAST);
        fdone   = done && div_q[9];
        word    = {shift_q[DATA_W-2:0], sd_s_q};
        accept  = !valid_q || out.ready;
        cnt_d   = cnt_q + 1'b1;
        neg     = -lpend_q;
        // The most negative sample has no positive twin; clamp it to full scale.
        if (!lpend_q[DATA_W-1])
            abs_a = lpend_q[DATA_W-2:0];
        else if (lpend_q[DATA_W-2:0] == '0)
            abs_a = '1;
        else
            abs_a = neg[DATA_W-2:0];
        max_a = (abs_a > run_q) ? abs_a : run_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            sd_m_q  <= 1'b0;
            sd_s_q  <= 1'b0;
            shift_q <= '0;
            lpend_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            pv_q    <= 1'b0;
            run_q   <= '0;
            peak_q  <= '0;
            cnt_q   <= '0;
        end else begin
            div_q  <= div_d;
            sd_m_q <= sd_i;
            sd_s_q <= sd_m_q;
            if (capture)
                shift_q <= word;
            if (done && !div_q[9])
                lpend_q <= word;
            if (fdone && accept) begin
                left_q  <= lpend_q;
                right_q <= word;
                valid_q <= 1'b1;
            end else if (valid_q && out.ready) begin
                valid_q <= 1'b0;
            end
            if (fdone && !accept)
                ovr_q <= 1'b1;
            else if (overrun_clr_i)
                ovr_q <= 1'b0;
            pv_q <= 1'b0;
            // Dropped frames still feed the meter, so it counts every frame.
            if (fdone) begin
                cnt_q <= cnt_d;
                if (cnt_d == '0) begin
                    peak_q <= max_a;
                    run_q  <= '0;
                    pv_q   <= 1'b1;
                end else begin
                    run_q <= max_a;
                end
            end
        end
    end

    assign bclk_o       = div_q[3];
    assign lrclk_o      = div_q[9];
    assign out.left     = left_q;
    assign out.right    = right_q;
    assign out.valid    = valid_q;
    assign overrun_o    = ovr_q;
    assign peak_o       = peak_q;
    assign peak_valid_o = pv_q;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: a microphone model driving sd on bclk falls
// and a table of frames with hand-computed outputs, plus reset/backpressure.
module tb_i2s_mic_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd = 1'b0;
    logic        bclk, lrclk, ovr, clr, pv;
    logic [22:0] peak;
    logic [9:0]  tdiv;
    int          n_chk = 0;
    int          n_fail = 0;

    i2s_mic_rx_if #(.DATA_W(24)) oif ();

    i2s_mic_rx #(.DATA_W(24), .PEAK_LOG2(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk_o       (bclk),
        .lrclk_o      (lrclk),
        .sd_i         (sd),
        .out          (oif.master),
        .overrun_o    (ovr),
        .overrun_clr_i(clr),
        .peak_o       (peak),
        .peak_valid_o (pv)
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) tdiv <= '0;
        else       tdiv <= tdiv + 10'd1;

    typedef struct {
        logic [23:0] l, r;
        logic        fill;
    } frm_t;

    typedef struct {
        logic [23:0] l, r;
        logic        fill, rdy, clr, ovm, v;
        logic [23:0] el, er;
        logic        ov, vn, pv;
        logic [22:0] pk;
    } vec_t;

    frm_t fq[$];
    frm_t cur = '{24'h0, 24'h0, 1'b0};
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_div(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tdiv != 10'(v) && n < 4000);
        if (tdiv != 10'(v)) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_div: div %0d required %0d", tdiv, v);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_clk"}, {30'd0, bclk, lrclk}, 32'd0);
        chk({nm, "_flags"}, {29'd0, oif.valid, ovr, pv}, 32'd0);
        chk({nm, "_left"}, {8'd0, oif.left}, 32'd0);
        chk({nm, "_right"}, {8'd0, oif.right}, 32'd0);
        chk({nm, "_peak"}, {9'd0, peak}, 32'd0);
    endtask

    // Microphone model: new bit launched just after each bclk fall.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (tdiv == 10'd0) begin
                if (fq.size() > 0) cur = fq.pop_front();
                else cur = '{24'h0, 24'h0, 1'b0};
            end
            if (tdiv[3:0] == 4'd0) begin
                automatic int k = int'(tdiv[8:4]);
                automatic logic [23:0] w = tdiv[9] ? cur.r : cur.l;
                if (k >= 1 && k <= 24) sd = w[24-k];
                else sd = cur.fill;
            end
        end
    end

    initial begin
        int n;
        tbl[0]  = '{24'h123456, 24'hABCDEF, 0, 1, 0, 0, 1, 24'h123456, 24'hABCDEF, 0, 0, 0, 23'h0};
        tbl[1]  = '{24'h000010, 24'h000000, 0, 1, 0, 0, 1, 24'h000010, 24'h000000, 0, 0, 0, 23'h0};
        tbl[2]  = '{24'hFFFF00, 24'h7FFFFF, 0, 1, 0, 0, 1, 24'hFFFF00, 24'h7FFFFF, 0, 0, 0, 23'h0};
        tbl[3]  = '{24'h800000, 24'h800001, 0, 1, 0, 0, 1, 24'h800000, 24'h800001, 0, 0, 1, 23'h7FFFFF};
        tbl[4]  = '{24'h000000, 24'h000000, 1, 1, 0, 0, 1, 24'h000000, 24'h000000, 0, 0, 0, 23'h7FFFFF};
        tbl[5]  = '{24'h000005, 24'h000006, 0, 1, 0, 0, 1, 24'h000005, 24'h000006, 0, 0, 0, 23'h7FFFFF};
        tbl[6]  = '{24'h000005, 24'hFFFFFF, 0, 1, 0, 0, 1, 24'h000005, 24'hFFFFFF, 0, 0, 0, 23'h7FFFFF};
        tbl[7]  = '{24'h000005, 24'h000005, 0, 1, 0, 0, 1, 24'h000005, 24'h000005, 0, 0, 1, 23'h000005};
        tbl[8]  = '{24'h000001, 24'h000010, 0, 0, 0, 0, 1, 24'h000001, 24'h000010, 0, 1, 0, 23'h000005};
        tbl[9]  = '{24'h000002, 24'h000020, 0, 0, 0, 0, 1, 24'h000001, 24'h000010, 1, 1, 0, 23'h000005};
        tbl[10] = '{24'h000003, 24'h000030, 0, 0, 0, 1, 1, 24'h000001, 24'h000010, 1, 1, 0, 23'h000005};
        tbl[11] = '{24'h000004, 24'h000040, 0, 0, 1, 0, 1, 24'h000001, 24'h000010, 1, 1, 1, 23'h000004};

        oif.ready = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_zero("reset");
        end
        fq.push_back('{24'h777777, 24'h111111, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;

        n = 0;
        while (!bclk && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bclk_first_rise", 32'(n), 32'd8);
        while (!lrclk && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("lrclk_first_rise", 32'(n), 32'd512);

        wait_div(600);
        chk("midframe_valid", {31'd0, oif.valid}, 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_zero("midreset");
        end

        for (int i = 0; i < 12; i++) begin
            if (i > 0) wait_div(1023);
            fq.push_back('{tbl[i].l, tbl[i].r, tbl[i].fill});
            oif.ready = tbl[i].rdy;
            clr = tbl[i].clr;
            if (i == 0) begin
                @(posedge clk);
                #1 reset = 1'b0;
            end
            wait_div(100);
            chk($sformatf("f%0d_ovr_mid", i + 1), {31'd0, ovr}, {31'd0, tbl[i].ovm});
            wait_div(907);
            chk($sformatf("f%0d_valid_pre", i + 1), {31'd0, oif.valid},
                {31'd0, (i >= 9)});
            wait_div(908);
            chk($sformatf("f%0d_valid", i + 1), {31'd0, oif.valid}, {31'd0, tbl[i].v});
            chk($sformatf("f%0d_left", i + 1), {8'd0, oif.left}, {8'd0, tbl[i].el});
            chk($sformatf("f%0d_right", i + 1), {8'd0, oif.right}, {8'd0, tbl[i].er});
            chk($sformatf("f%0d_ovr", i + 1), {31'd0, ovr}, {31'd0, tbl[i].ov});
            chk($sformatf("f%0d_pv", i + 1), {31'd0, pv}, {31'd0, tbl[i].pv});
            chk($sformatf("f%0d_peak", i + 1), {9'd0, peak}, {9'd0, tbl[i].pk});
            wait_div(909);
            chk($sformatf("f%0d_valid_next", i + 1), {31'd0, oif.valid}, {31'd0, tbl[i].vn});
            chk($sformatf("f%0d_pv_next", i + 1), {31'd0, pv}, 32'd0);
        end

        oif.ready = 1'b1;
        clr = 1'b0;
        chk("bp_left_held", {8'd0, oif.left}, 32'h1);
        @(negedge clk);
        chk("bp_valid_drop", {31'd0, oif.valid}, 32'd0);
        chk("bp_left_after", {8'd0, oif.left}, 32'h1);
        chk("bp_ovr_cleared", {31'd0, ovr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
